// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one 16-bit SRAM between CPU and DMA ports
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [15:0]       dma_addr,
    input  logic [15:0]       dma_wdata,
    output logic [15:0]       dma_rdata,
    output logic              dma_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ADDR,
    output logic [15:0]       Data_to_SRAM,
    input  logic [15:0]       Data_from_SRAM,
    output logic              sram_drive,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       owner_dma;
    logic       op_we;
    logic       last_dma;

    logic       grant;
    logic       grant_dma;
    logic       eff_dma;
    logic       eff_we;

    logic       ce_d;
    logic       oe_d;
    logic       we_d;
    logic       drive_d;
    logic       cpu_ack_d;
    logic       dma_ack_d;

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        grant     = cpu_req | dma_req;
        grant_dma = dma_req & (~cpu_req | ~last_dma);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pin controls are decoded from the next state and registered, so the
    // owner/direction of an access being granted right now comes from the request.
    always_comb begin
        eff_dma   = (state == IDLE) ? grant_dma : owner_dma;
        eff_we    = (state == IDLE) ? (grant_dma ? dma_we : cpu_we) : op_we;
        ce_d      = (state_next != ACCESS);
        oe_d      = !((state_next == ACCESS) && !eff_we);
        we_d      = !((state_next == ACCESS) && eff_we);
        drive_d   = (state_next == ACCESS) && eff_we;
        cpu_ack_d = (state_next == DONE) && !eff_dma;
        dma_ack_d = (state_next == DONE) && eff_dma;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            sram_drive   <= 1'b0;
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_rdata    <= 16'h0000;
            dma_rdata    <= 16'h0000;
            ADDR         <= '0;
            Data_to_SRAM <= 16'h0000;
            wait_cnt     <= 4'd0;
            owner_dma    <= 1'b0;
            op_we        <= 1'b0;
            last_dma     <= 1'b1;
        end else begin
            CE         <= ce_d;
            UB         <= ce_d;
            LB         <= ce_d;
            OE         <= oe_d;
            WE         <= we_d;
            sram_drive <= drive_d;
            cpu_ack    <= cpu_ack_d;
            dma_ack    <= dma_ack_d;

            if (state == IDLE && grant) begin
                ADDR         <= grant_dma ? ADDR_W'(dma_addr) : ADDR_W'(cpu_addr);
                Data_to_SRAM <= grant_dma ? dma_wdata : cpu_wdata;
                owner_dma    <= grant_dma;
                op_we        <= grant_dma ? dma_we : cpu_we;
                last_dma     <= grant_dma;
                wait_cnt     <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS) begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end else if (!op_we) begin
                    if (owner_dma) begin
                        dma_rdata <= Data_from_SRAM;
                    end else begin
                        cpu_rdata <= Data_from_SRAM;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single external 1Mx16 SRAM between two requesters: the CPU memory interface (MAR/MDR path) and a secondary loader/DMA port. It arbitrates with round-robin priority and sequences each access through fixed wait states. It drives the active-low SRAM controls (CE, UB, LB, OE, WE), and returns read data with a one-cycle acknowledge. It sits between the CPU top level and the SRAM pins, replacing direct MAR-to-ADDR wiring.

Parameters:
WAIT_CYCLES, 2, number of cycles CE and OE/WE stay asserted per access; legal range 1..15
ADDR_W, 20, SRAM address width; the 16-bit request addresses are zero-extended

Ports:
Clk  input  1  system clock; all logic on the rising edge
Reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU access request; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  16  CPU word address
cpu_wdata  input  16  CPU write data
cpu_rdata  output  16  read data; valid when cpu_ack=1
cpu_ack  output  1  one-cycle completion pulse
dma_req  input  1  loader/DMA request; held until dma_ack
dma_we  input  1  1 = write, 0 = read
dma_addr  input  16  DMA word address
dma_wdata  input  16  DMA write data
dma_rdata  output  16  read data; valid when dma_ack=1
dma_ack  output  1  one-cycle completion pulse
busy  output  1  1 when the state is not IDLE
ADDR  output  ADDR_W  SRAM address, registered at grant
Data_to_SRAM  output  16  write data, registered at grant
Data_from_SRAM  input  16  SRAM read data
sram_drive  output  1  tristate enable for the data pins; 1 only during write ACCESS
CE, UB, LB, OE, WE  output  1 each  active-low SRAM controls

Behaviour:
- Reset values:
  - state = IDLE
  - CE = UB = LB = OE = WE = 1
  - sram_drive = 0, busy = 0, both acks = 0
  - cpu_rdata = dma_rdata = 0, ADDR = 0, Data_to_SRAM = 0
  - last_grant = DMA, so the CPU wins the first tie
- States are IDLE, ACCESS and DONE.
- IDLE:
  - Samples both req inputs.
  - Only one request high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - On grant, register ADDR = {zeros, addr}, Data_to_SRAM = wdata, the grant owner and we.
  - Also on grant: update last_grant, load wait counter = WAIT_CYCLES-1, and go to ACCESS.
- ACCESS:
  - CE = UB = LB = 0 (16-bit accesses only).
  - Read: OE = 0, WE = 1.
  - Write: OE = 1, WE = 0, sram_drive = 1.
  - The counter decrements each cycle.
  - When the counter = 0: on a read, capture Data_from_SRAM into the owner's rdata register; then go to DONE.
- DONE:
  - All controls return to 1 and sram_drive = 0 (write recovery / bus turnaround).
  - The owner's ack = 1 for exactly this cycle.
  - Next state is IDLE.
- Control outputs are registered (decoded from next-state) so there are no glitches on the SRAM pins.
- Latency: req sampled at edge t; ACCESS occupies cycles t+1..t+WAIT_CYCLES; ack is high in cycle t+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- rdata holds its value until the next read by the same owner completes. Writes do not change rdata.
- Requester rule: req must be low in the cycle after ack, unless the requester is issuing a new access. A req high in IDLE is always a new request.
- An access is non-abortable. If req drops during ACCESS, the access still completes and ack still pulses.
- Requests are not sampled during ACCESS or DONE. A non-granted requester waits with req held and is granted in the next IDLE.
- Reset asserted in any state: on the next edge, go to IDLE with reset values. No ack is issued for the interrupted access.
- WAIT_CYCLES = 1: ACCESS lasts exactly one cycle.

Test Plan:
- Reset checks: hold Reset for 3 cycles → all controls 1, acks 0, rdata 0, busy 0. Then raise cpu_req in the same cycle Reset deasserts → request is not granted until the first IDLE sample after reset.
- CPU read at 0x3000, WAIT_CYCLES=2, SRAM model returns 0xBEEF:
  - CE/OE low for exactly 2 cycles and ADDR = 0x03000.
  - cpu_ack high in the 3rd cycle after the sample edge, with cpu_rdata = 0xBEEF.
  - dma_rdata unchanged.
- DMA write 0x1234 to 0x0042:
  - WE low for 2 cycles with sram_drive = 1, Data_to_SRAM = 0x1234, ADDR = 0x00042.
  - OE stays 1; dma_ack pulses once.
  - A following CPU read of 0x0042 returns 0x1234.
- Both requests held continuously for 4 accesses → grant order is CPU, DMA, CPU, DMA, with one ack per access and no overlap.
- Reset asserted in the 2nd ACCESS cycle of a write → next cycle is IDLE, WE = 1, no ack. A re-issued request then completes normally.
- WAIT_CYCLES=1, CPU drops cpu_req mid-ACCESS → the access completes and cpu_ack pulses in the 2nd cycle after the sample.
